// File: rtl/frame_dmac_replace_if.sv
// Descriptor, packet-buffer read and transmit-FIFO signals of frame_dmac_replace.
// The slave modport is the DMAC-replace stage; master is its surroundings.
interface frame_dmac_replace_if;
  logic [47:0]  iv_dmac;
  logic [8:0]   iv_bufid;
  logic         i_dmac_replace_flag;
  logic         i_lookup_table_match_flag;
  logic         i_descriptor_wr;
  logic         o_descriptor_ready;
  logic         o_pkt_rd;
  logic [15:0]  ov_pkt_raddr;
  logic [133:0] iv_pkt_rdata;
  logic [8:0]   iv_fifo_usedw;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic         o_pkt_bufid_wr;
  logic [8:0]   ov_pkt_bufid;

  modport master (
    output iv_dmac, iv_bufid, i_dmac_replace_flag, i_lookup_table_match_flag,
           i_descriptor_wr, iv_pkt_rdata, iv_fifo_usedw,
    input  o_descriptor_ready, o_pkt_rd, ov_pkt_raddr, ov_data, o_data_wr,
           o_pkt_bufid_wr, ov_pkt_bufid
  );

  modport slave (
    input  iv_dmac, iv_bufid, i_dmac_replace_flag, i_lookup_table_match_flag,
           i_descriptor_wr, iv_pkt_rdata, iv_fifo_usedw,
    output o_descriptor_ready, o_pkt_rd, ov_pkt_raddr, ov_data, o_data_wr,
           o_pkt_bufid_wr, ov_pkt_bufid
  );
endinterface

// File: rtl/frame_dmac_replace.sv
// Reads a looked-up frame from the packet buffer, overwrites the DMAC field of the
// first word when requested, streams it to the transmit FIFO and releases the buffer.
module frame_dmac_replace #(
  parameter logic [8:0] START_THRESHOLD = 9'd384
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  frame_dmac_replace_if.slave  io,
  output logic [15:0]          ov_tx_pkt_cnt,
  output logic [15:0]          ov_discard_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, READ} state_e;

  state_e        state_q, state_d;
  logic [8:0]    bufid_q, bufid_d;
  logic [47:0]   dmac_q, dmac_d;
  logic          replace_q, replace_d;
  logic [6:0]    offset_q, offset_d;
  logic          rd_q, rd_d;
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    lst_q, lst_d;
  logic [1:0]    first_q, first_d;
  logic [133:0]  data_q, data_d;
  logic          data_wr_q, data_wr_d;
  logic          rel_q, rel_d;
  logic [8:0]    rel_bufid_q, rel_bufid_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [15:0]   disc_cnt_q, disc_cnt_d;
  logic [133:0]  word;
  logic          ready;

  assign ready = (state_q == IDLE) && !i_rst;

  always_comb begin
    state_d     = state_q;
    bufid_d     = bufid_q;
    dmac_d      = dmac_q;
    replace_d   = replace_q;
    offset_d    = offset_q;
    rd_d        = rd_q;
    data_d      = data_q;
    data_wr_d   = 1'b0;
    rel_d       = 1'b0;
    rel_bufid_d = rel_bufid_q;
    tx_cnt_d    = tx_cnt_q;
    disc_cnt_d  = disc_cnt_q;
    // Per-read tags travel with the 2-cycle read latency so the returning word knows its position.
    vld_d       = {vld_q[0], rd_q};
    lst_d       = {lst_q[0], rd_q && (offset_q == 7'd127)};
    first_d     = {first_q[0], rd_q && (offset_q == 7'd0)};

    word = io.iv_pkt_rdata;
    if (first_q[1] && replace_q) word[127:80] = dmac_q;
    if (lst_q[1]) word[132] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (io.i_descriptor_wr && ready) begin
          bufid_d   = io.iv_bufid;
          dmac_d    = io.iv_dmac;
          replace_d = io.i_dmac_replace_flag;
          offset_d  = '0;
          if (io.i_lookup_table_match_flag) begin
            state_d = WAIT_SPACE;
          end else begin
            rel_d       = 1'b1;
            rel_bufid_d = io.iv_bufid;
            disc_cnt_d  = disc_cnt_q + 16'd1;
          end
        end
      end
      WAIT_SPACE: begin
        if (io.iv_fifo_usedw < START_THRESHOLD) begin
          rd_d     = 1'b1;
          offset_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        if (rd_q) begin
          if (offset_q == 7'd127) rd_d = 1'b0;
          else                    offset_d = offset_q + 7'd1;
        end
        if (vld_q[1]) begin
          data_d    = word;
          data_wr_d = 1'b1;
          // The tail ends the frame; the two reads still in flight are dropped here.
          if (word[132]) begin
            rd_d        = 1'b0;
            vld_d       = '0;
            lst_d       = '0;
            first_d     = '0;
            rel_d       = 1'b1;
            rel_bufid_d = bufid_q;
            tx_cnt_d    = tx_cnt_q + 16'd1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      bufid_q     <= '0;
      dmac_q      <= '0;
      replace_q   <= 1'b0;
      offset_q    <= '0;
      rd_q        <= 1'b0;
      vld_q       <= '0;
      lst_q       <= '0;
      first_q     <= '0;
      data_q      <= '0;
      data_wr_q   <= 1'b0;
      rel_q       <= 1'b0;
      rel_bufid_q <= '0;
      tx_cnt_q    <= '0;
      disc_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bufid_q     <= bufid_d;
      dmac_q      <= dmac_d;
      replace_q   <= replace_d;
      offset_q    <= offset_d;
      rd_q        <= rd_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      first_q     <= first_d;
      data_q      <= data_d;
      data_wr_q   <= data_wr_d;
      rel_q       <= rel_d;
      rel_bufid_q <= rel_bufid_d;
      tx_cnt_q    <= tx_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
    end
  end

  assign io.o_descriptor_ready = ready;
  assign io.o_pkt_rd           = rd_q;
  assign io.ov_pkt_raddr       = {bufid_q, offset_q};
  assign io.ov_data            = data_q;
  assign io.o_data_wr          = data_wr_q;
  assign io.o_pkt_bufid_wr     = rel_q;
  assign io.ov_pkt_bufid       = rel_bufid_q;
  assign ov_tx_pkt_cnt         = tx_cnt_q;
  assign ov_discard_pkt_cnt    = disc_cnt_q;

endmodule

// File: tb/tb_frame_dmac_replace.sv
// Directed bench for frame_dmac_replace: packet buffer model with 2-cycle read latency,
// hand-computed expectations checked with immediate assertions.
module tb_frame_dmac_replace;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] tx_cnt;
  logic [15:0] disc_cnt;

  frame_dmac_replace_if bus ();

  frame_dmac_replace #(.START_THRESHOLD(9'd384)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .io                 (bus.slave),
    .ov_tx_pkt_cnt      (tx_cnt),
    .ov_discard_pkt_cnt (disc_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Packet buffer: word at addr = {head, tail, addr[3:0], 8 x addr}; frame_len 0 means no tail.
  int unsigned  frame_len = 1;
  logic         v1 = 1'b0;
  logic [15:0]  a1 = '0;

  function automatic logic [133:0] gen_word(input logic [15:0] addr);
    logic [6:0] off;
    off = addr[6:0];
    return {off == 7'd0, (frame_len != 0) && (32'(off) == frame_len - 1), addr[3:0], {8{addr}}};
  endfunction

  always @(posedge i_clk) begin
    v1 <= bus.o_pkt_rd;
    a1 <= bus.ov_pkt_raddr;
    bus.iv_pkt_rdata <= v1 ? gen_word(a1) : '1;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [8:0] id, input logic [47:0] mac, input logic rep, input logic match);
    bus.iv_bufid                  = id;
    bus.iv_dmac                   = mac;
    bus.i_dmac_replace_flag       = rep;
    bus.i_lookup_table_match_flag = match;
    bus.i_descriptor_wr           = 1'b1;
  endtask

  // Observations of one frame, cycle 0 = descriptor accept cycle.
  int unsigned  n_rd, n_wr, rd_first_c, wr_first_c, wr_last_c;
  int           rel_c;
  logic [15:0]  rd_first, rd_last;
  logic [8:0]   rel_bufid;
  logic         rdy_at_rel;
  logic [133:0] words [128];

  task automatic collect(input int unsigned budget, input int unsigned drop_c);
    n_rd = 0; n_wr = 0; rel_c = -1; rd_first_c = 0; wr_first_c = 0; wr_last_c = 0;
    rd_first = '0; rd_last = '0; rel_bufid = '0; rdy_at_rel = 1'b0;
    for (int unsigned c = 0; c < budget && rel_c < 0; c++) begin
      if (bus.o_pkt_rd) begin
        if (n_rd == 0) begin rd_first_c = c; rd_first = bus.ov_pkt_raddr; end
        rd_last = bus.ov_pkt_raddr;
        n_rd++;
      end
      if (bus.o_data_wr) begin
        if (n_wr < 128) words[n_wr] = bus.ov_data;
        if (n_wr == 0) wr_first_c = c;
        wr_last_c = c;
        n_wr++;
      end
      if (bus.o_pkt_bufid_wr) begin
        rel_c      = int'(c);
        rel_bufid  = bus.ov_pkt_bufid;
        rdy_at_rel = bus.o_descriptor_ready;
      end
      tick();
      if (c == 0) bus.i_descriptor_wr = 1'b0;
      if (c + 1 == drop_c) bus.iv_fifo_usedw = 9'd100;
    end
    check("release_seen", 134'(rel_c >= 0), 134'(1));
  endtask

  initial begin
    i_rst = 1'b1;
    bus.iv_dmac = '0; bus.iv_bufid = '0; bus.i_dmac_replace_flag = 1'b0;
    bus.i_lookup_table_match_flag = 1'b0; bus.i_descriptor_wr = 1'b0;
    bus.iv_fifo_usedw = '0;
    tick(); tick();
    check("rst_ready", 134'(bus.o_descriptor_ready), 134'(0));
    check("rst_rd", 134'(bus.o_pkt_rd), 134'(0));
    check("rst_data", bus.ov_data, 134'(0));
    check("rst_relwr", 134'(bus.o_pkt_bufid_wr), 134'(0));
    check("rst_txcnt", 134'(tx_cnt), 134'(0));
    i_rst = 1'b0;
    #1;
    check("idle_ready", 134'(bus.o_descriptor_ready), 134'(1));

    // 3-word frame with DMAC replacement
    frame_len = 3;
    send(9'd5, 48'h0011_2233_4455, 1'b1, 1'b1);
    collect(40, 0);
    check("t1_nrd", 134'(n_rd), 134'(5));
    check("t1_rd_first_c", 134'(rd_first_c), 134'(2));
    check("t1_rd_first", 134'(rd_first), 134'(16'h0280));
    check("t1_rd_last", 134'(rd_last), 134'(16'h0284));
    check("t1_nwr", 134'(n_wr), 134'(3));
    check("t1_wr_first_c", 134'(wr_first_c), 134'(5));
    check("t1_wr_last_c", 134'(wr_last_c), 134'(7));
    check("t1_w0", words[0], {1'b1, 1'b0, 4'h0, 48'h0011_2233_4455, {5{16'h0280}}});
    check("t1_w1", words[1], {2'b00, 4'h1, {8{16'h0281}}});
    check("t1_w2", words[2], {2'b01, 4'h2, {8{16'h0282}}});
    check("t1_rel_c", 134'(rel_c), 134'(7));
    check("t1_rel_id", 134'(rel_bufid), 134'(5));
    check("t1_rdy_at_rel", 134'(rdy_at_rel), 134'(1));
    check("t1_txcnt", 134'(tx_cnt), 134'(1));
    check("t1_rd_after", 134'(bus.o_pkt_rd), 134'(0));

    // 1-word frame, no replacement
    frame_len = 1;
    send(9'd7, 48'hAAAA_BBBB_CCCC, 1'b0, 1'b1);
    collect(40, 0);
    check("t2_nrd", 134'(n_rd), 134'(3));
    check("t2_nwr", 134'(n_wr), 134'(1));
    check("t2_w0", words[0], {2'b11, 4'h0, {8{16'h0380}}});
    check("t2_rel_c", 134'(rel_c), 134'(5));
    check("t2_rel_id", 134'(rel_bufid), 134'(7));
    check("t2_txcnt", 134'(tx_cnt), 134'(2));

    // Back-to-back discards
    for (int k = 1; k <= 4; k++) begin
      send(9'(k), 48'h0, 1'b0, 1'b0);
      check("t3_ready", 134'(bus.o_descriptor_ready), 134'(1));
      tick();
      check("t3_relwr", 134'(bus.o_pkt_bufid_wr), 134'(1));
      check("t3_relid", 134'(bus.ov_pkt_bufid), 134'(k));
      check("t3_no_rd", 134'(bus.o_pkt_rd), 134'(0));
    end
    bus.i_descriptor_wr = 1'b0;
    tick();
    check("t3_relwr_end", 134'(bus.o_pkt_bufid_wr), 134'(0));
    check("t3_disccnt", 134'(disc_cnt), 134'(4));

    // FIFO too full for 10 cycles
    frame_len = 2;
    bus.iv_fifo_usedw = 9'd400;
    send(9'd2, 48'hFFFF_0000_1234, 1'b1, 1'b1);
    collect(60, 10);
    check("t4_rd_first_c", 134'(rd_first_c), 134'(11));
    check("t4_rd_first", 134'(rd_first), 134'(16'h0100));
    check("t4_nrd", 134'(n_rd), 134'(4));
    check("t4_wr_first_c", 134'(wr_first_c), 134'(14));
    check("t4_rel_c", 134'(rel_c), 134'(15));
    check("t4_w0", words[0], {1'b1, 1'b0, 4'h0, 48'hFFFF_0000_1234, {5{16'h0100}}});
    check("t4_w1", words[1], {2'b01, 4'h1, {8{16'h0101}}});

    // Frame without tail: stops at offset 127
    frame_len = 0;
    send(9'd3, 48'h0, 1'b0, 1'b1);
    collect(200, 0);
    check("t5_nrd", 134'(n_rd), 134'(128));
    check("t5_rd_last", 134'(rd_last), 134'(16'h01FF));
    check("t5_nwr", 134'(n_wr), 134'(128));
    check("t5_wr_last_c", 134'(wr_last_c), 134'(132));
    check("t5_rel_c", 134'(rel_c), 134'(132));
    check("t5_w0", words[0], {2'b10, 4'h0, {8{16'h0180}}});
    check("t5_w127", words[127], {2'b01, 4'hF, {8{16'h01FF}}});
    check("t5_txcnt", 134'(tx_cnt), 134'(4));

    // Reset while word 2 of a 4-word frame is being written
    frame_len = 4;
    send(9'd4, 48'h0, 1'b0, 1'b1);
    tick();
    bus.i_descriptor_wr = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    check("t6_w2_wr", 134'(bus.o_data_wr), 134'(1));
    check("t6_w2", bus.ov_data, {2'b00, 4'h2, {8{16'h0202}}});
    i_rst = 1'b1;
    tick();
    check("t6_rst_wr", 134'(bus.o_data_wr), 134'(0));
    check("t6_rst_rd", 134'(bus.o_pkt_rd), 134'(0));
    check("t6_rst_raddr", 134'(bus.ov_pkt_raddr), 134'(0));
    check("t6_rst_data", bus.ov_data, 134'(0));
    check("t6_rst_relwr", 134'(bus.o_pkt_bufid_wr), 134'(0));
    check("t6_rst_txcnt", 134'(tx_cnt), 134'(0));
    check("t6_rst_ready", 134'(bus.o_descriptor_ready), 134'(0));
    i_rst = 1'b0;
    #1;
    check("t6_ready", 134'(bus.o_descriptor_ready), 134'(1));
    frame_len = 2;
    send(9'd6, 48'h1234_5678_9ABC, 1'b1, 1'b1);
    collect(40, 0);
    check("t6_nwr", 134'(n_wr), 134'(2));
    check("t6_rel_c", 134'(rel_c), 134'(6));
    check("t6_rel_id", 134'(rel_bufid), 134'(6));
    check("t6_w0", words[0], {1'b1, 1'b0, 4'h0, 48'h1234_5678_9ABC, {5{16'h0300}}});
    check("t6_txcnt", 134'(tx_cnt), 134'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_dmac_replace.md
# frame_dmac_replace

Downstream stage of the frame inverse-mapping lookup in the host transmit path. Consumes one lookup result per frame (bufid, DMAC, replace/match flags), reads the frame from the packet buffer, overwrites the TSNtag in the destination-MAC field with the looked-up DMAC when required, streams the frame to the transmit FIFO and releases the buffer. Frames whose lookup missed are discarded without a buffer read.

## Interface
- START_THRESHOLD, 9'd384: a frame read starts only when iv_fifo_usedw < START_THRESHOLD, which reserves 128 words of space.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- iv_dmac  in  48  DMAC from the lookup.
- iv_bufid  in  9  packet buffer id.
- i_dmac_replace_flag  in  1  1 = overwrite data[127:80] of the first word.
- i_lookup_table_match_flag  in  1  0 = discard the frame.
- i_descriptor_wr  in  1  lookup result valid.
- o_descriptor_ready  out  1  high only in IDLE and not in reset; combinational.
- o_pkt_rd  out  1  packet buffer read strobe.
- ov_pkt_raddr  out  16  read address {bufid, offset[6:0]}.
- iv_pkt_rdata  in  134  read data, valid 2 cycles after o_pkt_rd. Bit 133 = head, bit 132 = tail, [131:128] = byte info, [127:0] = payload.
- iv_fifo_usedw  in  9  transmit FIFO fill level.
- ov_data  out  134  frame word to the transmit FIFO.
- o_data_wr  out  1  ov_data valid.
- o_pkt_bufid_wr  out  1  buffer release strobe, 1-cycle pulse.
- ov_pkt_bufid  out  9  buffer to release.
- ov_tx_pkt_cnt  out  16  frames forwarded; wraps at 16'hFFFF.
- ov_discard_pkt_cnt  out  16  frames discarded; wraps at 16'hFFFF.

## Operation
- All outputs are registered except o_descriptor_ready. On reset every output is 0, offset = 0, the read-valid pipe is cleared and the state is IDLE.
- IDLE: a descriptor is accepted when i_descriptor_wr & o_descriptor_ready. bufid, dmac and replace_flag are latched.
  - If match_flag = 0: assert o_pkt_bufid_wr next cycle with ov_pkt_bufid = bufid, increment ov_discard_pkt_cnt, stay in IDLE.
  - If match_flag = 1: go to WAIT_SPACE.
- WAIT_SPACE: wait, with no timeout, until iv_fifo_usedw < START_THRESHOLD. Then set o_pkt_rd = 1 with offset 0 and go to READ.
- READ:
  - Issue one read per cycle, incrementing the offset.
  - After the read at offset 127 is issued, stop issuing. Never wrap into the next buffer.
  - A 2-stage shift register tracks in-flight reads. Each returning valid word is written with o_data_wr = 1.
  - The first returned word has data[127:80] replaced by the latched dmac if replace_flag = 1. All other bits pass through unchanged.
- Completion: a returned word with bit 132 = 1, or the word from offset 127 (bit 132 forced to 1), is the last word. In that same register update:
  - write the last word,
  - clear o_pkt_rd and the valid pipe, which drops the 2 overshoot reads,
  - pulse o_pkt_bufid_wr with ov_pkt_bufid = bufid,
  - increment ov_tx_pkt_cnt,
  - go to IDLE.
- No output backpressure. The threshold check guarantees FIFO space for a worst-case 128-word frame.
- Reset mid-frame aborts the frame. The buffer is not released, and no partial tail is produced.

## Timing
- Descriptor (match) accepted in cycle 0. WAIT_SPACE is cycle 1 with space available. o_pkt_rd is high from cycle 2 at offset 0.
- For an N-word frame:
  - reads are issued in cycles 2..N+3 (N+2 reads),
  - o_data_wr is high in cycles 5..N+4,
  - o_pkt_bufid_wr pulses in cycle N+4,
  - o_descriptor_ready is high in cycle N+4, so the next descriptor can be accepted in cycle N+4.
- Discard: accepted in cycle 0, o_pkt_bufid_wr in cycle 1, ready in cycle 1. Back-to-back discards sustain 1 descriptor per cycle.
- Each cycle spent in WAIT_SPACE shifts all read and output cycles by 1.

## Test plan
- Match, replace = 1, dmac = 48'h0011_2233_4455, bufid = 9'd5, 3-word frame -> 3 writes in cycles 5–7. Word 0 has [127:80] = dmac, other bits unchanged. Release of bufid 5 in cycle 7. ov_tx_pkt_cnt = 1. 5 reads issued, at raddr 16'h0280..16'h0284.
- Match, replace = 0, 1-word frame (bits 133 and 132 both set) -> word passes through unchanged. Release in cycle 5.
- match = 0 on 4 consecutive cycles with bufids 1–4 -> releases of 1–4 in cycles 1–4. No o_pkt_rd. ov_discard_pkt_cnt = 4.
- iv_fifo_usedw = 400 for 10 cycles, then 100 -> no read while usedw ≥ 384. First read 1 cycle after the drop.
- Frame with no tail bit -> exactly 128 data writes, the last with bit 132 forced to 1. Highest raddr offset = 127, then release.
- i_rst asserted mid-frame at word 2 -> all outputs 0 next cycle, no release. After reset is removed, ready is high and a new descriptor is processed normally.
